// File: rtl/mem_dump_stream_pkg.sv
// Shared types, constants and helpers for the memory-dump streaming engine.
// Symbol selection and the control FSM both derive their sizing from here.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
        ST_NEXT
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Wide enough for the largest symbol count (64-bit word in hex: 16 + 2).
    localparam int IDX_W = 5;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic int syms_per_word(input int data_w, input int hex_mode);
        return (hex_mode != 0) ? (data_w / 4 + 2) : (data_w / 8);
    endfunction

endpackage

// File: rtl/mem_dump_stream_if.sv
// Bundles the Avalon-MM read port and the byte stream toward the UART.
// The dump engine is the master; memory and stream sink sit on the slave side.
interface mem_dump_stream_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_waitrequest;
    logic [DATA_W-1:0] mem_data;
    logic              mem_readdatavalid;
    logic              uart_valid;
    logic              uart_ready;
    logic [7:0]        uart_data;

    modport master (
        output mem_addr,
        output mem_read,
        input  mem_waitrequest,
        input  mem_data,
        input  mem_readdatavalid,
        output uart_valid,
        output uart_data,
        input  uart_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        output mem_waitrequest,
        output mem_data,
        output mem_readdatavalid,
        input  uart_valid,
        input  uart_data,
        output uart_ready
    );
endinterface

// File: rtl/mem_dump_stream_word_serializer.sv
// Latches one memory word and emits it as 8-bit symbols over valid/ready,
// either raw little-endian bytes or uppercase ASCII hex followed by CR LF.
module word_serializer
    import mem_dump_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int HEX_MODE = 0
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_last,
    output logic              o_valid,
    output logic [7:0]        o_data,
    input  logic              i_ready
);

    localparam int SYMS = syms_per_word(DATA_W, HEX_MODE);
    localparam int NIBS = DATA_W / 4;
    localparam int TBL  = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

    logic [DATA_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic              r_valid;

    logic              w_fire;
    logic              w_at_last;
    logic [7:0]        w_syms [TBL];

    // Full power-of-two table so the index never selects outside the array.
    genvar gi;
    generate
        for (gi = 0; gi < TBL; gi++) begin : g_sym
            if (gi >= SYMS) begin : g_unused
                assign w_syms[gi] = 8'h00;
            end else if (HEX_MODE != 0) begin : g_hex
                if (gi < NIBS) begin : g_nib
                    assign w_syms[gi] = nibble_to_ascii(r_word[DATA_W-4-4*gi +: 4]);
                end else if (gi == NIBS) begin : g_cr
                    assign w_syms[gi] = ASCII_CR;
                end else begin : g_lf
                    assign w_syms[gi] = ASCII_LF;
                end
            end else begin : g_raw
                assign w_syms[gi] = r_word[8*gi +: 8];
            end
        end
    endgenerate

    assign w_fire    = r_valid & i_ready;
    assign w_at_last = (r_idx == LAST_IDX);
    assign o_last    = w_fire & w_at_last;
    assign o_valid   = r_valid;
    // Forced to zero when idle so the bus reads 0 out of reset in hex mode too.
    assign o_data    = r_valid ? w_syms[r_idx] : 8'h00;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            if (w_at_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_dump_stream.sv
// Memory-dump engine: on start, reads START_ADDR..END_ADDR one word at a time
// over Avalon-MM and streams each word out as bytes through word_serializer.
module mem_dump_stream
    import mem_dump_pkg::*;
#(
    parameter int                ADDR_W     = 17,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = {ADDR_W{1'b1}},
    parameter int                HEX_MODE   = 0
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    mem_dump_stream_if.master  bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mem_read;
    logic              r_busy;
    logic              r_done;

    logic              w_load;
    logic              w_last;
    logic              w_at_end;

    // Read data is only taken while waiting for it; strays elsewhere are dropped.
    assign w_load   = (r_state == ST_WAIT) && bus.mem_readdatavalid;
    assign w_at_end = (r_addr == END_ADDR);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_addr     <= START_ADDR;
            r_mem_read <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr     <= START_ADDR;
                        r_mem_read <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!bus.mem_waitrequest) begin
                        r_mem_read <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_readdatavalid) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // done is raised on entry to NEXT so it pulses right after the last handshake.
                    if (w_last) begin
                        r_state <= ST_NEXT;
                        if (w_at_end) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end
                end
                ST_NEXT: begin
                    if (w_at_end) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_mem_read <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign bus.mem_addr = r_addr;
    assign bus.mem_read = r_mem_read;

    word_serializer #(
        .DATA_W   (DATA_W),
        .HEX_MODE (HEX_MODE)
    ) u_ser (
        .clk     (clk),
        .nreset  (nreset),
        .i_load  (w_load),
        .i_word  (bus.mem_data),
        .o_last  (w_last),
        .o_valid (bus.uart_valid),
        .o_data  (bus.uart_data),
        .i_ready (bus.uart_ready)
    );

endmodule

// File: tb/tb_mem_dump_stream.sv
// Directed bench: one raw-mode dumper over words 0..1 and one hex-mode dumper
// over the single word at address 5, each with its own memory model and sink.
module tb_mem_dump_stream;

    logic clk     = 1'b0;
    logic nreset  = 1'b0;
    logic start_r = 1'b0;
    logic start_h = 1'b0;
    logic busy_r, done_r, busy_h, done_h;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_dump_stream_if #(.ADDR_W(17), .DATA_W(32)) ra ();
    mem_dump_stream_if #(.ADDR_W(17), .DATA_W(32)) rh ();

    mem_dump_stream #(
        .ADDR_W(17), .DATA_W(32), .START_ADDR(17'd0), .END_ADDR(17'd1), .HEX_MODE(0)
    ) dut_raw (
        .clk(clk), .nreset(nreset), .start(start_r), .busy(busy_r), .done(done_r), .bus(ra.master)
    );

    mem_dump_stream #(
        .ADDR_W(17), .DATA_W(32), .START_ADDR(17'd5), .END_ADDR(17'd5), .HEX_MODE(1)
    ) dut_hex (
        .clk(clk), .nreset(nreset), .start(start_h), .busy(busy_h), .done(done_h), .bus(rh.master)
    );

    logic [31:0] mem_r [4];
    logic [31:0] mem_h [8];
    logic [7:0]  exp_raw [8]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0]  exp_hex [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raw-side memory model: accept sampled at negedge, data returned the next cycle.
    int          stall_cnt = 0;
    bit          stray     = 1'b0;
    bit          acc_r     = 1'b0;
    logic [16:0] acc_addr_r;
    int          n_reads_r = 0;
    int          rd_cyc_r  = 0;

    initial begin
        ra.mem_waitrequest   = 1'b0;
        ra.mem_readdatavalid = 1'b0;
        ra.mem_data          = '0;
        forever begin
            @(posedge clk); #1;
            if (acc_r && nreset) begin
                ra.mem_readdatavalid = 1'b1;
                ra.mem_data          = mem_r[acc_addr_r[1:0]];
            end else begin
                ra.mem_readdatavalid = stray;
                if (stray) ra.mem_data = 32'hBAD0_BAD0;
            end
            if (ra.mem_read && stall_cnt > 0) begin
                ra.mem_waitrequest = 1'b1;
                stall_cnt--;
            end else begin
                ra.mem_waitrequest = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        acc_r = nreset && ra.mem_read && !ra.mem_waitrequest;
        if (acc_r) begin
            acc_addr_r = ra.mem_addr;
            n_reads_r++;
        end
        if (nreset && ra.mem_read) rd_cyc_r++;
    end

    // Hex-side memory model: never stalls.
    bit          acc_h = 1'b0;
    logic [16:0] acc_addr_h;

    initial begin
        rh.mem_waitrequest   = 1'b0;
        rh.mem_readdatavalid = 1'b0;
        rh.mem_data          = '0;
        forever begin
            @(posedge clk); #1;
            rh.mem_readdatavalid = acc_h && nreset;
            if (acc_h && nreset) rh.mem_data = mem_h[acc_addr_h[2:0]];
        end
    end

    always @(negedge clk) begin
        acc_h = nreset && rh.mem_read && !rh.mem_waitrequest;
        if (acc_h) acc_addr_h = rh.mem_addr;
    end

    // Stream monitors: capture handshakes and check hold/stability rules.
    logic [7:0]  q_raw [$];
    logic [7:0]  q_hex [$];
    int          cyc = 0;
    int          last_hs = 0;
    int          n_done_r = 0;
    int          n_done_h = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    bit          prev_wait = 1'b0;
    logic [16:0] prev_addr;

    always @(negedge clk) begin
        cyc++;
        if (nreset && ra.uart_valid && ra.uart_ready) begin
            q_raw.push_back(ra.uart_data);
            last_hs = cyc;
        end
        if (nreset && rh.uart_valid && rh.uart_ready) q_hex.push_back(rh.uart_data);
        if (nreset && done_r) begin
            n_done_r++;
            chk("done_after_last_hs", cyc, last_hs + 1);
            chk("busy_low_with_done", busy_r, 1'b0);
        end
        if (nreset && done_h) n_done_h++;
        if (nreset && prev_stall) begin
            chk("valid_held_in_stall", ra.uart_valid, 1'b1);
            chk("data_held_in_stall", ra.uart_data, prev_data);
        end
        if (nreset && prev_wait) begin
            chk("read_held_in_wait", ra.mem_read, 1'b1);
            chk("addr_held_in_wait", ra.mem_addr, prev_addr);
        end
        prev_stall = nreset && ra.uart_valid && !ra.uart_ready;
        prev_data  = ra.uart_data;
        prev_wait  = nreset && ra.mem_read && ra.mem_waitrequest;
        prev_addr  = ra.mem_addr;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input bit hex, input string tag);
        int k = 0;
        while (!(hex ? done_h : done_r) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_timeout"}, (k < 300), 1'b1);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (q_raw.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_bytes_timeout"}, (k < 300), 1'b1);
    endtask

    task automatic expect_raw(input string tag);
        chk({tag, "_len"}, q_raw.size(), 8);
        for (int i = 0; i < 8 && i < q_raw.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), q_raw[i], exp_raw[i]);
        q_raw.delete();
    endtask

    task automatic pulse_start_raw();
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
    endtask

    int base_done, base_reads, base_cyc;

    initial begin
        mem_r[0] = 32'h4433_2211;
        mem_r[1] = 32'h8877_6655;
        mem_r[2] = '0;
        mem_r[3] = '0;
        for (int i = 0; i < 8; i++) mem_h[i] = 32'h0;
        mem_h[5] = 32'hDEAD_BEEF;
        ra.uart_ready = 1'b1;
        rh.uart_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        chk("rst_busy", busy_r, 1'b0);
        chk("rst_done", done_r, 1'b0);
        chk("rst_mem_read", ra.mem_read, 1'b0);
        chk("rst_mem_addr", ra.mem_addr, 17'd0);
        chk("rst_uart_valid", ra.uart_valid, 1'b0);
        chk("rst_uart_data", ra.uart_data, 8'h00);
        chk("rst_hex_addr", rh.mem_addr, 17'd5);
        chk("rst_hex_data", rh.uart_data, 8'h00);
        nreset = 1'b1;
        tick();

        // Raw dump of words 0..1 with ready tied high
        base_done  = n_done_r;
        base_reads = n_reads_r;
        pulse_start_raw();
        chk("t1_read_rise", ra.mem_read, 1'b1);
        chk("t1_busy_rise", busy_r, 1'b1);
        chk("t1_first_addr", ra.mem_addr, 17'd0);
        wait_done(1'b0, "t1");
        tick();
        chk("t1_busy_after", busy_r, 1'b0);
        chk("t1_done_count", n_done_r - base_done, 1);
        chk("t1_read_count", n_reads_r - base_reads, 2);
        expect_raw("t1");

        // Hex dump of the single word at address 5
        base_done = n_done_h;
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        wait_done(1'b1, "t2");
        tick();
        chk("t2_len", q_hex.size(), 10);
        for (int i = 0; i < 10 && i < q_hex.size(); i++)
            chk($sformatf("t2_b%0d", i), q_hex[i], exp_hex[i]);
        chk("t2_done_count", n_done_h - base_done, 1);
        q_hex.delete();

        // Waitrequest held for 3 cycles on the first read
        base_reads = n_reads_r;
        base_cyc   = rd_cyc_r;
        stall_cnt  = 3;
        pulse_start_raw();
        wait_done(1'b0, "t3");
        tick();
        chk("t3_read_cycles", rd_cyc_r - base_cyc, 5);
        chk("t3_read_count", n_reads_r - base_reads, 2);
        expect_raw("t3");

        // Sink not ready for 5 cycles in mid-word
        pulse_start_raw();
        wait_bytes(3, "t4");
        tick();
        ra.uart_ready = 1'b0;
        repeat (5) tick();
        ra.uart_ready = 1'b1;
        wait_done(1'b0, "t4");
        tick();
        expect_raw("t4");

        // Start while busy plus a stray readdatavalid during SEND
        base_reads = n_reads_r;
        base_done  = n_done_r;
        pulse_start_raw();
        wait_bytes(1, "t5");
        stray   = 1'b1;
        start_r = 1'b1;
        @(negedge clk);
        stray   = 1'b0;
        start_r = 1'b0;
        wait_done(1'b0, "t5");
        // A start coinciding with done is ignored, the next cycle's start is taken.
        start_r = 1'b1;
        tick();
        chk("t5_start_on_done_busy", busy_r, 1'b0);
        chk("t5_start_on_done_read", ra.mem_read, 1'b0);
        tick();
        start_r = 1'b0;
        chk("t5_restart_busy", busy_r, 1'b1);
        chk("t5_restart_read", ra.mem_read, 1'b1);
        chk("t5_read_count", n_reads_r - base_reads, 2);
        chk("t5_done_count", n_done_r - base_done, 1);
        expect_raw("t5");
        wait_done(1'b0, "t5b");
        tick();
        expect_raw("t5b");

        // Reset during SEND of the second word
        pulse_start_raw();
        wait_bytes(5, "t6");
        tick();
        nreset = 1'b0;
        #1;
        chk("t6_rst_busy", busy_r, 1'b0);
        chk("t6_rst_done", done_r, 1'b0);
        chk("t6_rst_read", ra.mem_read, 1'b0);
        chk("t6_rst_addr", ra.mem_addr, 17'd0);
        chk("t6_rst_valid", ra.uart_valid, 1'b0);
        chk("t6_rst_data", ra.uart_data, 8'h00);
        tick();
        nreset = 1'b1;
        q_raw.delete();
        tick();
        pulse_start_raw();
        chk("t6_restart_addr", ra.mem_addr, 17'd0);
        wait_done(1'b0, "t6");
        tick();
        expect_raw("t6");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_dump_stream.md
# mem_dump_stream

Parametrised memory-dump engine. On a start pulse it walks a configurable word range of an Avalon-MM read slave, such as the on-chip flash data port, one word at a time. Each word is serialised into 8-bit symbols on a valid/ready stream that feeds the UART transmitter. It supports configurable data width and address range, raw little-endian or ASCII-hex output, and start/busy/done control, where the previous dumper only streamed raw bytes.

## Interface
- ADDR_W, 17: word-address width of the memory bus.
- DATA_W, 32: memory data width; multiple of 8, range 8..64.
- START_ADDR, 0: first word address, inclusive.
- END_ADDR, 2**ADDR_W-1: last word address, inclusive; must be ≥ START_ADDR.
- HEX_MODE, 0: 0 = raw bytes; 1 = uppercase ASCII hex plus CR LF per word.
- clk  in  1  single clock.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a dump; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last symbol is accepted.
- mem_addr  out  ADDR_W  Avalon-MM word address.
- mem_read  out  1  Avalon-MM read request.
- mem_waitrequest  in  1  slave stall.
- mem_data  in  DATA_W  read data.
- mem_readdatavalid  in  1  read data qualifier.
- uart_valid  out  1  symbol valid.
- uart_ready  in  1  sink ready.
- uart_data  out  8  symbol.

## Operation
- FSM states: IDLE → REQ → WAIT → SEND → (NEXT) → REQ or IDLE.
- IDLE: start=1 loads the address register with START_ADDR and goes to REQ.
- REQ: mem_read=1 with mem_addr stable. When mem_waitrequest=0 the request is accepted and the FSM goes to WAIT.
- WAIT: mem_read=0. On mem_readdatavalid=1, latch mem_data, clear the symbol index and go to SEND.
- SEND: present symbol[idx]. On uart_valid&uart_ready, increment idx. The last symbol goes to NEXT.
- NEXT: if addr==END_ADDR, pulse done and go to IDLE. Otherwise addr+1 and go to REQ.
- Symbol count SYMS is DATA_W/8 in raw mode and DATA_W/4+2 in hex mode.
- Raw mode is little-endian: byte [7:0] is sent first.
- Hex mode:
  - Nibbles are sent most-significant first, as '0'-'9' (0x30-0x39) and 'A'-'F' (0x41-0x46).
  - Each word is followed by 0x0D, 0x0A.
- Only one read is outstanding at any time. mem_readdatavalid outside WAIT is ignored.
- Address arithmetic is ADDR_W-bit. Termination is by equality with END_ADDR, so there is no wrap past END_ADDR.
- Reset values: busy=0, done=0, mem_read=0, mem_addr=START_ADDR, uart_valid=0, uart_data=0. Idx and the latched word are 0.
- Reset mid-operation aborts immediately. An in-flight read is abandoned and the FSM returns to IDLE.

## Timing
- mem_read rises the cycle after start is sampled.
- mem_addr and mem_read are held unchanged while mem_waitrequest=1.
- mem_read falls the cycle after acceptance.
- uart_valid rises the cycle after readdatavalid.
- uart_data is held stable while uart_valid=1 and uart_ready=0. uart_valid never drops without a handshake.
- With uart_ready tied high, one symbol is sent per cycle.
- The next mem_read is asserted 2 cycles after the last handshake of a word (NEXT, then REQ).
- done pulses in the cycle after the final handshake. busy falls in the same cycle.
- A start in the same cycle as done is ignored. A start on the following cycle is accepted.

## Structure
- Package mem_dump_pkg holds:
  - the state enum;
  - the ASCII_CR and ASCII_LF constants;
  - a nibble_to_ascii function;
  - a syms_per_word(DATA_W, HEX_MODE) function.
- Sub-module word_serializer holds the latched word, the index counter, symbol selection and the valid/ready handshake. It exposes load, last and the stream ports.
- The top FSM owns the address register and the Avalon-MM signals.

## Test plan
- Raw mode, DATA_W=32, range 0..1, words 0x44332211 and 0x88776655, ready=1: bytes 11 22 33 44 55 66 77 88 are sent, then one done pulse.
- Hex mode, single word 0xDEADBEEF with START_ADDR=END_ADDR: bytes 44 45 41 44 42 45 45 46 0D 0A are sent, then done.
- mem_waitrequest held high for 3 cycles: mem_read and mem_addr stay constant for 4 cycles, and exactly one read is issued.
- uart_ready low for 5 cycles in mid-word: uart_valid and uart_data are stable, and no symbol is lost or duplicated.
- start pulsed while busy, and a stray readdatavalid in SEND: both are ignored and the output sequence is unchanged.
- nreset asserted during SEND:
  - all outputs go to their reset values immediately;
  - a fresh start after release dumps again from START_ADDR.
